// File: rtl/spi_master_rx.sv
// rtl/spi_master_rx.sv - SPI master receive shifter: packs single/quad samples into 32-bit words.
// Optional SPI_MASTER_RX_BSWAP_EN byte-swaps each word as it is pushed.
module spi_master_rx (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        rx_edge,
  output logic        rx_done,
  input  logic        sdi0,
  input  logic        sdi1,
  input  logic        sdi2,
  input  logic        sdi3,
  input  logic        en_quad_in,
  input  logic [15:0] counter_in,
  input  logic        counter_in_upd,
  output logic [31:0] data,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        clk_en_o
);

  typedef enum logic [1:0] {IDLE, RECEIVE, WAIT_FIFO, WAIT_DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] counter_q, counter_d;
  logic [15:0] trgt_q, trgt_d;
  logic [31:0] sh_q, sh_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic [31:0] sh_next, push_word;
  logic        rx_active, done, reg_done, push;

  always_comb begin
    sh_next = en_quad_in ? {sh_q[27:0], sdi3, sdi2, sdi1, sdi0} : {sh_q[30:0], sdi0};
`ifdef SPI_MASTER_RX_BSWAP_EN
    push_word = {sh_next[7:0], sh_next[15:8], sh_next[23:16], sh_next[31:24]};
`else
    push_word = sh_next;
`endif
    trgt_d = trgt_q;
    if (counter_in_upd) begin
      trgt_d = en_quad_in ? {2'b00, counter_in[15:2]} : counter_in;
    end
    rx_active = rx_edge && (state_q == RECEIVE);
    done      = rx_active && (counter_q == trgt_q - 16'd1);
    reg_done  = rx_active && (en_quad_in ? (counter_q[2:0] == 3'h7) : (counter_q[4:0] == 5'h1F));
    push      = done || reg_done;
  end

  // Post-push data_valid is always 1, so "output free next cycle" reduces to data_ready.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    sh_d      = sh_q;
    data_d    = data_q;
    valid_d   = valid_q && !data_ready;
    clk_en_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d   = RECEIVE;
          counter_d = 16'd0;
        end
      end
      RECEIVE: begin
        clk_en_o = 1'b1;
        if (rx_edge) begin
          counter_d = counter_q + 16'd1;
          sh_d      = sh_next;
          if (push) begin
            data_d  = push_word;
            valid_d = 1'b1;
            sh_d    = 32'd0;
          end
          if (done) begin
            counter_d = 16'd0;
            state_d   = data_ready ? IDLE : WAIT_DONE;
          end else if (reg_done && !data_ready) begin
            state_d = WAIT_FIFO;
          end
        end
      end
      WAIT_FIFO: begin
        if (valid_q && data_ready) state_d = RECEIVE;
      end
      WAIT_DONE: begin
        if (valid_q && data_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      counter_q <= 16'd0;
      trgt_q    <= 16'h8;
      sh_q      <= 32'd0;
      data_q    <= 32'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      trgt_q    <= trgt_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  assign rx_done    = done;
  assign data       = data_q;
  assign data_valid = valid_q;

endmodule

// File: tb/tb_spi_master_rx.sv
// tb/tb_spi_master_rx.sv - directed self-checking bench for spi_master_rx.
module tb_spi_master_rx;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        rx_edge = 1'b0;
  logic        rx_done;
  logic        sdi0 = 1'b0, sdi1 = 1'b0, sdi2 = 1'b0, sdi3 = 1'b0;
  logic        en_quad_in = 1'b0;
  logic [15:0] counter_in = 16'd0;
  logic        counter_in_upd = 1'b0;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready = 1'b1;
  logic        clk_en_o;

  spi_master_rx dut (
    .clk(clk), .rstn(rstn), .en(en), .rx_edge(rx_edge), .rx_done(rx_done),
    .sdi0(sdi0), .sdi1(sdi1), .sdi2(sdi2), .sdi3(sdi3),
    .en_quad_in(en_quad_in), .counter_in(counter_in), .counter_in_upd(counter_in_upd),
    .data(data), .data_valid(data_valid), .data_ready(data_ready), .clk_en_o(clk_en_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int edge_idx = 0;
  int done_edge = -1;
  int n_done = 0;
  int valid_cycles = 0;
  logic [31:0] got_q[$];

  always @(negedge clk) begin
    if (rstn) begin
      if (data_valid) valid_cycles++;
      if (data_valid && data_ready) got_q.push_back(data);
      if (rx_done) begin
        n_done++;
        done_edge = edge_idx;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef SPI_MASTER_RX_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] cnt, input logic quad, input logic upd);
    en_quad_in = quad;
    counter_in = cnt;
    counter_in_upd = upd;
    cycle();
    counter_in_upd = 1'b0;
    en = 1'b1;
    cycle();
    en = 1'b0;
  endtask

  task automatic send(input logic [63:0] bits, input int nedges, input logic quad);
    edge_idx = 0;
    for (int i = 0; i < nedges; i++) begin
      int b = 0;
      while (!clk_en_o && b < 500) begin
        cycle();
        b++;
      end
      if (!clk_en_o) begin
        check("clk_en_wait", {31'd0, clk_en_o}, 32'd1);
        return;
      end
      if (quad) {sdi3, sdi2, sdi1, sdi0} = bits[4*(nedges-1-i) +: 4];
      else sdi0 = bits[nedges-1-i];
      rx_edge = 1'b1;
      edge_idx = i + 1;
      cycle();
      rx_edge = 1'b0;
      cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, d0, v0;
    repeat (3) cycle();
    check("rst_data", data, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_clk_en", {31'd0, clk_en_o}, 32'd0);
    check("rst_rx_done", {31'd0, rx_done}, 32'd0);
    rstn = 1'b1;
    cycle();

    // rx_edge while IDLE must be ignored
    b = got_q.size(); d0 = n_done;
    sdi0 = 1'b1;
    repeat (3) begin rx_edge = 1'b1; cycle(); end
    rx_edge = 1'b0;
    repeat (3) cycle();
    check("idle_edge_words", got_q.size() - b, 0);
    check("idle_edge_done", n_done - d0, 0);

    b = got_q.size(); d0 = n_done; v0 = valid_cycles;
    start(16'd32, 1'b0, 1'b1);
    send(64'hA5A51234, 32, 1'b0);
    repeat (3) cycle();
    check("s32_words", got_q.size() - b, 1);
    if (got_q.size() > b) check("s32_data", got_q[b], sw(32'hA5A51234));
    check("s32_valid_cycles", valid_cycles - v0, 1);
    check("s32_ndone", n_done - d0, 1);
    check("s32_done_edge", done_edge, 32);
    check("s32_idle", {31'd0, clk_en_o}, 32'd0);

    b = got_q.size();
    start(16'd64, 1'b1, 1'b1);
    send(64'h123456789ABCDEF0, 16, 1'b1);
    repeat (3) cycle();
    check("quad_words", got_q.size() - b, 2);
    if (got_q.size() > b + 1) begin
      check("quad_w0", got_q[b], sw(32'h12345678));
      check("quad_w1", got_q[b+1], sw(32'h9ABCDEF0));
    end
    check("quad_done_edge", done_edge, 16);

    b = got_q.size();
    data_ready = 1'b0;
    start(16'd64, 1'b0, 1'b1);
    fork
      send(64'hDEADBEEF01234567, 64, 1'b0);
      begin
        int w = 0;
        while (!data_valid && w < 300) begin
          @(negedge clk);
          w++;
        end
        repeat (20) @(negedge clk);
        check("bp_clk_en", {31'd0, clk_en_o}, 32'd0);
        check("bp_valid", {31'd0, data_valid}, 32'd1);
        check("bp_data", data, sw(32'hDEADBEEF));
        check("bp_no_accept", got_q.size() - b, 0);
        data_ready = 1'b1;
      end
    join
    repeat (3) cycle();
    check("bp_words", got_q.size() - b, 2);
    if (got_q.size() > b + 1) begin
      check("bp_w0", got_q[b], sw(32'hDEADBEEF));
      check("bp_w1", got_q[b+1], sw(32'h01234567));
    end
    check("bp_idle", {31'd0, clk_en_o}, 32'd0);

    b = got_q.size();
    start(16'd12, 1'b0, 1'b1);
    send(64'hABC, 12, 1'b0);
    repeat (3) cycle();
    check("p12_words", got_q.size() - b, 1);
    if (got_q.size() > b) check("p12_data", got_q[b], sw(32'h00000ABC));
    check("p12_done_edge", done_edge, 12);

    start(16'd32, 1'b0, 1'b1);
    send(64'h3FF, 10, 1'b0);
    rstn = 1'b0;
    cycle();
    check("mid_rst_valid", {31'd0, data_valid}, 32'd0);
    check("mid_rst_clk_en", {31'd0, clk_en_o}, 32'd0);
    rstn = 1'b1;
    cycle();
    b = got_q.size();
    start(16'd0, 1'b0, 1'b0);
    send(64'h5A, 8, 1'b0);
    repeat (3) cycle();
    check("post_rst_words", got_q.size() - b, 1);
    if (got_q.size() > b) check("post_rst_data", got_q[b], sw(32'h0000005A));
    check("post_rst_done_edge", done_edge, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
